mul_acc_seq: RTL and testbench

Sequential shift-add multiply-accumulate that rebuilds a dividend from a divisor, quotient and remainder: `did = quo*div + rem`. It is the inverse of the combinational restoring divider used in the coordinate-scaling path. It lets the stroke planner rescale divided step counts back to motor-step units. It also gives verification a round-trip check against the divider. The block uses the same `M`/`N` width convention as the divider and the same `error` convention for a zero divisor.

---
 rtl/mul_acc_seq.sv | 90 +++++++++
 tb/tb_mul_acc_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mul_acc_seq.sv
// Sequential shift-add multiply-accumulate: rebuilds did = quo*div + rem over N+1 cycles.
// A zero divisor flags error, forces did to 0 and skips the iterations.
module mul_acc_seq #(
   parameter int M = 9,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [M:0]     quo,
   input  logic [N:0]     div,
   input  logic [M:0]     rem,
   output logic [M+N+1:0] did,
   output logic           busy,
   output logic           done,
   output logic           error
);

   localparam int AW = M + N + 2;
   localparam int CW = (N > 0) ? $clog2(N + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state, state_next;
   logic [M:0]     mc;
   logic [N:0]     mp;
   logic [AW-1:0]  acc;
   logic [AW-1:0]  addend;
   logic [AW-1:0]  acc_sum;
   logic [CW-1:0]  cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A zero-divisor request spends a single CALC cycle with no arithmetic,
   // so done appears one cycle after the accepting edge.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (error || cnt == CNT_LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   always_comb begin
      addend  = AW'(mc) << cnt;
      acc_sum = mp[0] ? (acc + addend) : acc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mc    <= '0;
         mp    <= '0;
         acc   <= '0;
         cnt   <= '0;
         did   <= '0;
         error <= 1'b0;
      end else if (state == IDLE && start) begin
         mc    <= quo;
         mp    <= div;
         acc   <= AW'(rem);
         cnt   <= '0;
         error <= (div == '0);
         if (div == '0) begin
            did <= '0;
         end
      end else if (state == CALC && !error) begin
         acc <= acc_sum;
         mp  <= mp >> 1;
         cnt <= cnt + 1'b1;
         if (cnt == CNT_LAST) begin
            did <= acc_sum;
         end
      end
   end

endmodule

// File: tb/tb_mul_acc_seq.sv
// Directed and randomized checks of mul_acc_seq against an arithmetic model (quo*div+rem).
module tb_mul_acc_seq;

   localparam int M = 9;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [M:0]     quo;
   logic [N:0]     div;
   logic [M:0]     rem;
   logic [M+N+1:0] did;
   logic           busy;
   logic           done;
   logic           error;

   int checks   = 0;
   int failures = 0;

   mul_acc_seq #(.M(M), .N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .quo   (quo),
      .div   (div),
      .rem   (rem),
      .did   (did),
      .busy  (busy),
      .done  (done),
      .error (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation from an idle DUT; caller is positioned 1 time unit after a rising edge.
   task automatic run_op(input logic [M:0] q, input logic [N:0] d, input logic [M:0] r,
                         input string tag);
      logic [M+N+1:0] exp_did;
      logic           exp_err;
      int             lat, busy_n, exp_lat;
      exp_err = (d == 0);
      exp_did = exp_err ? '0 : (M+N+2)'(int'(q) * int'(d) + int'(r));
      exp_lat = exp_err ? 1 : N + 1;
      quo = q; div = d; rem = r; start = 1'b1;
      tick();
      start = 1'b0;
      quo = (M+1)'($urandom); div = (N+1)'($urandom); rem = (M+1)'($urandom);
      busy_n = busy ? 1 : 0;
      lat = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
         if (busy) busy_n++;
      end
      check({tag, "_lat"},  64'(lat),     64'(exp_lat));
      check({tag, "_did"},  64'(did),     64'(exp_did));
      check({tag, "_err"},  64'(error),   64'(exp_err));
      check({tag, "_busy"}, 64'(busy_n),  64'(exp_lat + 1));
      tick();
      check({tag, "_end"},  64'({done, busy}), 64'(0));
      $display("op %s quo=%0d div=%0d rem=%0d did=%0d error=%0d lat=%0d",
               tag, q, d, r, did, error, lat);
   endtask

   initial begin
      int t;
      int n;
      int dones;
      int times[$];
      logic [M:0] q, r;
      logic [N:0] d;
      int orig;

      rst_n = 1'b0; start = 1'b0; quo = '0; div = '0; rem = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_did",   64'(did),   64'(0));
      check("rst_busy",  64'(busy),  64'(0));
      check("rst_done",  64'(done),  64'(0));
      check("rst_error", 64'(error), 64'(0));
      rst_n = 1'b1;
      tick();

      run_op(10'd23,   5'd5,  10'd3,    "basic");
      run_op(10'd1023, 5'd31, 10'd1023, "max");
      run_op(10'd7,    5'd0,  10'd2,    "zero_div");
      run_op(10'd4,    5'd3,  10'd1,    "after_zero");

      // start pulsed during CALC must be ignored
      quo = 10'd23; div = 5'd5; rem = 10'd3; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      start = 1'b1; quo = 10'd100; div = 5'd7; rem = 10'd5;
      tick();
      start = 1'b0;
      n = 3;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      check("ign_lat", 64'(n),   64'(N + 1));
      check("ign_did", 64'(did), 64'(118));
      dones = 0;
      repeat (10) begin
         tick();
         if (done) dones++;
      end
      check("ign_no_extra_done", 64'(dones), 64'(0));
      $display("op ignored_start did=%0d extra_dones=%0d", did, dones);

      // start held high: back-to-back results every N+3 cycles
      quo = 10'd4; div = 5'd3; rem = 10'd1; start = 1'b1;
      for (t = 1; t <= 25; t++) begin
         tick();
         if (done) begin
            times.push_back(t);
            check("held_did", 64'(did), 64'(13));
         end
      end
      start = 1'b0;
      check("held_count", 64'(times.size()), 64'(3));
      if (times.size() >= 2) begin
         check("held_first", 64'(times[0]),            64'(N + 2));
         check("held_gap",   64'(times[1] - times[0]), 64'(N + 3));
      end
      $display("op held_start results=%0d", times.size());
      n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      check("held_idle", 64'(busy), 64'(0));

      // reset in the third CALC cycle
      quo = 10'd23; div = 5'd5; rem = 10'd3; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      #3 rst_n = 1'b0;
      #1;
      check("arst_did",   64'(did),   64'(0));
      check("arst_busy",  64'(busy),  64'(0));
      check("arst_done",  64'(done),  64'(0));
      check("arst_error", 64'(error), 64'(0));
      #2 rst_n = 1'b1;
      dones = 0;
      repeat (10) begin
         tick();
         if (done || busy) dones++;
      end
      check("arst_quiet", 64'(dones), 64'(0));
      $display("op reset_mid_calc did=%0d", did);

      // round-trip against divider outputs
      for (int i = 0; i < 12; i++) begin
         orig = int'($urandom_range(0, 1023));
         d    = (N+1)'($urandom_range(1, 31));
         q    = (M+1)'(orig / int'(d));
         r    = (M+1)'(orig % int'(d));
         run_op(q, d, r, "roundtrip");
         check("roundtrip_orig", 64'(did), 64'(orig));
      end

      // unconstrained operands, including non-canonical rem and occasional zero divisor
      for (int i = 0; i < 12; i++) begin
         q = (M+1)'($urandom);
         d = (i % 6 == 5) ? '0 : (N+1)'($urandom);
         r = (M+1)'($urandom);
         run_op(q, d, r, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
